// File: rtl/prgrom_uart_loader.sv
// Loads a program image into the instruction ROM from a big-endian UART byte stream.
// A word is written one cycle after its 4th byte. Done is asserted one cycle after the last write or after the idle timeout.
// There is no backpressure: every rx_valid byte in RECV/WRITE is taken, and rx_valid in IDLE/DONE is dropped.
module prgrom_uart_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384,
  parameter int TIMEOUT   = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_pg,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              prog_mode,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        byte_cnt;
  logic [TMR_W-1:0]  timer;
  logic              accept;
  logic              seen_byte;
  logic              timeout_hit;
  logic [ADDR_W:0]   count_inc;

  // A byte is taken in RECV, and in WRITE as byte 0 of the next word.
  assign accept      = rx_valid && (state == RECV || state == WRITE);
  // The idle timer only runs once the session has actually received something.
  assign seen_byte   = (word_count != '0) || (byte_cnt != 2'd0);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state == RECV) && !rx_valid && seen_byte && (timer == TMR_LAST);
  assign count_inc   = word_count + 1'b1;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded outputs; outputs come straight off the state flops.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    done       = 1'b0;
    prog_mode  = 1'b0;
    case (state)
      IDLE: begin
        if (start_pg) state_next = RECV;
      end
      RECV: begin
        prog_mode = 1'b1;
        if (rx_valid && byte_cnt == 2'd3) state_next = WRITE;
        else if (timeout_hit)             state_next = DONE;
      end
      WRITE: begin
        prog_mode  = 1'b1;
        mem_we     = 1'b1;
        state_next = (count_inc == CNT_LAST) ? DONE : RECV;
      end
      DONE: begin
        prog_mode  = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: byte assembly, address/count advance, idle timer and error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      byte_cnt   <= 2'd0;
      timer      <= '0;
      error      <= 1'b0;
    end else begin
      if (state == IDLE && start_pg) begin
        mem_addr   <= '0;
        word_count <= '0;
        byte_cnt   <= 2'd0;
        timer      <= '0;
        error      <= 1'b0;
      end
      if (accept) begin
        mem_wdata <= {mem_wdata[23:0], rx_data};
        byte_cnt  <= byte_cnt + 2'd1;
        timer     <= '0;
      end else if (state == RECV && seen_byte) begin
        if (timeout_hit) begin
          // A partial word is dropped and flagged.
          error <= (byte_cnt != 2'd0);
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
      // Address and count advance as the single write cycle ends; the address wraps naturally.
      if (state == WRITE) begin
        mem_addr   <= mem_addr + 1'b1;
        word_count <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_prgrom_uart_loader.sv
// Self-checking bench for prgrom_uart_loader: randomized byte sessions against a queue-based model.
// Expected writes and session ends are queued by the driver and popped by an independent monitor.
// Every wait on the DUT is bounded in cycles.
module tb_prgrom_uart_loader;

  localparam int ADDR_W    = 2;
  localparam int MAX_WORDS = 4;
  localparam int TIMEOUT   = 50;

  logic              clock;
  logic              reset;
  logic              start_pg;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              prog_mode;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  prgrom_uart_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start_pg(start_pg), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .prog_mode(prog_mode),
    .done(done), .error(error), .word_count(word_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                idx;
  } wr_t;

  typedef struct {
    int   count;
    logic err;
  } end_t;

  wr_t  exp_wr[$];
  end_t exp_end[$];

  int checks;
  int errors;
  int done_cnt;
  int sess_target;

  // Reference model: session flag, words completed, bytes of the current word.
  bit         in_session;
  int         words;
  logic [7:0] cur[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t  w;
    end_t e;
    if (!in_session) return;
    cur.push_back(b);
    if (cur.size() == 4) begin
      w.addr = ADDR_W'(words % (1 << ADDR_W));
      w.data = {cur[0], cur[1], cur[2], cur[3]};
      w.idx  = words;
      exp_wr.push_back(w);
      cur.delete();
      words++;
      if (words == MAX_WORDS) begin
        e.count = words;
        e.err   = 1'b0;
        exp_end.push_back(e);
        in_session = 0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic start();
    start_pg = 1'b1;
    if (!in_session) begin
      in_session  = 1;
      words       = 0;
      cur.delete();
      sess_target = done_cnt + 1;
    end
    tick();
    start_pg = 1'b0;
  endtask

  // start_pg and a byte together in IDLE: the session opens and the byte is lost.
  task automatic start_with_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    start();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < sess_target && n < 400) begin
      tick();
      n++;
    end
    if (done_cnt < sess_target) begin
      checks++;
      errors++;
      $display("FAIL wait_done actual=no_done expected=done");
    end
  endtask

  task automatic end_by_timeout();
    end_t e;
    e.count = words;
    e.err   = (cur.size() != 0);
    exp_end.push_back(e);
    in_session = 0;
    cur.delete();
    wait_done();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic monitor_loop();
    wr_t               w;
    end_t              e;
    logic [ADDR_W-1:0] nxt_addr;
    int                nxt_cnt;
    bit                after_we;
    bit                after_done;
    after_we   = 0;
    after_done = 0;
    nxt_addr   = '0;
    nxt_cnt    = 0;
    forever begin
      @(negedge clock);
      if (after_we) begin
        chk("addr_after_write", mem_addr, nxt_addr);
        chk("count_after_write", word_count, nxt_cnt);
        after_we = 0;
      end
      if (after_done) begin
        chk("prog_mode_after_done", prog_mode, 1'b0);
        after_done = 0;
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          fail_event("unexpected_write");
        end else begin
          w = exp_wr.pop_front();
          chk("write_addr", mem_addr, w.addr);
          chk("write_data", mem_wdata, w.data);
          chk("prog_mode_in_write", prog_mode, 1'b1);
          nxt_addr = w.addr + 2'd1;
          nxt_cnt  = w.idx + 1;
          after_we = 1;
        end
      end
      if (done) begin
        if (exp_end.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          e = exp_end.pop_front();
          chk("done_word_count", word_count, e.count);
          chk("done_error", error, e.err);
          chk("prog_mode_in_done", prog_mode, 1'b1);
        end
        done_cnt++;
        after_done = 1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_we"},     mem_we,     1'b0);
    chk({tag, "_mem_addr"},   mem_addr,   '0);
    chk({tag, "_mem_wdata"},  mem_wdata,  32'h0);
    chk({tag, "_prog_mode"},  prog_mode,  1'b0);
    chk({tag, "_done"},       done,       1'b0);
    chk({tag, "_error"},      error,      1'b0);
    chk({tag, "_word_count"}, word_count, '0);
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    done_cnt    = 0;
    sess_target = 0;
    in_session  = 0;
    words       = 0;
    reset       = 1'b1;
    start_pg    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    fork
      monitor_loop();
    join_none
    gap(2);
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Directed first word, then timeout with one whole word.
    start();
    send_byte(8'h3C);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h10);
    end_by_timeout();
    tick();

    // Three random words with gaps; a stray start_pg mid-session must be ignored.
    start();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom));
      if (i == 5) start();
      gap($urandom_range(0, 3));
    end
    end_by_timeout();
    tick();

    // Five bytes: one word plus a dropped partial word.
    start();
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom));
      gap($urandom_range(0, 2));
    end
    end_by_timeout();
    chk("error_sticky", error, 1'b1);
    tick();

    // Back-to-back stream up to MAX_WORDS, including bytes during WRITE; address wraps.
    start();
    for (int i = 0; i < 4 * MAX_WORDS; i++) send_byte(8'($urandom));
    wait_done();
    tick();

    // Bytes in IDLE are ignored; start_pg together with a byte drops that byte.
    send_byte(8'hAA);
    send_byte(8'h55);
    gap(2);
    start_with_byte(8'hEE);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    gap(3);

    // Asynchronous reset mid-word: outputs clear at once, no further write.
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    chk("pending_writes_at_reset", exp_wr.size(), 0);
    chk("pending_ends_at_reset", exp_end.size(), 0);
    in_session = 0;
    cur.delete();
    words = 0;
    tick();
    reset = 1'b0;
    tick();

    // Reload after reset starts from address 0.
    start();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    end_by_timeout();
    tick();

    // Random sessions: either timeout or reaching MAX_WORDS.
    for (int s = 0; s < 5; s++) begin
      start();
      n = $urandom_range(1, 18);
      for (int i = 0; i < n && in_session; i++) begin
        send_byte(8'($urandom));
        gap($urandom_range(0, 3));
      end
      if (in_session) end_by_timeout();
      else            wait_done();
      tick();
    end

    gap(3);
    chk("final_writes_drained", exp_wr.size(), 0);
    chk("final_ends_drained", exp_end.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
